// File: rtl/regex_imem_arbiter_pkg.sv
// regex_imem_arbiter_pkg: shared state encoding and stats width for the instruction-memory arbiter
package regex_imem_arbiter_pkg;
  typedef enum logic [1:0] {SERVE, DRAIN, LOAD} arb_state_e;
  localparam int STATS_COUNT_WIDTH = 16;
endpackage

// File: rtl/regex_imem_arbiter_if.sv
// regex_imem_arbiter_if: CPU fetch ports, program-load stream and instruction BRAM bus
interface regex_imem_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int MEMORY_WIDTH = 16
);
  logic [N_PORTS-1:0] cpu_valid;
  logic [N_PORTS*MEMORY_ADDR_WIDTH-1:0] cpu_addr;
  logic [N_PORTS-1:0] cpu_ready;
  logic [MEMORY_WIDTH-1:0] cpu_data;
  logic load_start;
  logic load_valid;
  logic [MEMORY_ADDR_WIDTH-1:0] load_addr;
  logic [MEMORY_WIDTH-1:0] load_data;
  logic load_last;
  logic load_ready;
  logic loading;
  logic mem_en;
  logic mem_we;
  logic [MEMORY_ADDR_WIDTH-1:0] mem_addr;
  logic [MEMORY_WIDTH-1:0] mem_wdata;
  logic [MEMORY_WIDTH-1:0] mem_rdata;
  modport slave (
    input cpu_valid, cpu_addr, load_start, load_valid, load_addr, load_data, load_last, mem_rdata,
    output cpu_ready, cpu_data, load_ready, loading, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output cpu_valid, cpu_addr, load_start, load_valid, load_addr, load_data, load_last, mem_rdata,
    input cpu_ready, cpu_data, load_ready, loading, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/regex_imem_arbiter_rr_priority_picker.sv
// regex_imem_arbiter_rr_priority_picker: one-hot round-robin pick starting just after i_ptr
module regex_imem_arbiter_rr_priority_picker #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);
  logic [PW-1:0] w_p;
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_p = '0;
    for (int k = 1; k <= N; k++) begin
      w_p = PW'((int'(i_ptr) + k) % N);
      if (!o_any && i_req[w_p]) begin
        o_gnt[w_p] = 1'b1;
        o_idx = w_p;
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regex_imem_arbiter.sv
// regex_imem_arbiter: round-robin IMEM fetch arbiter with program-load session; IMEM_ARB_STATS_EN adds per-port grant counters
module regex_imem_arbiter
  import regex_imem_arbiter_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int MEMORY_WIDTH = 16
) (
  input logic clk,
  input logic reset,
  regex_imem_arbiter_if.slave bus
`ifdef IMEM_ARB_STATS_EN
  ,
  input  logic stats_clear,
  output logic [N_PORTS*STATS_COUNT_WIDTH-1:0] grant_count
`endif
);
  localparam int PTR_WIDTH = $clog2(N_PORTS);
  arb_state_e r_state, w_next;
  logic [PTR_WIDTH-1:0] r_ptr, w_idx;
  logic [N_PORTS-1:0] w_gnt, w_ready;
  logic w_any, w_serve, w_load, w_rd, w_wr;
  regex_imem_arbiter_rr_priority_picker #(.N(N_PORTS), .PW(PTR_WIDTH)) u_pick (
    .i_req(bus.cpu_valid),
    .i_ptr(r_ptr),
    .o_gnt(w_gnt),
    .o_idx(w_idx),
    .o_any(w_any)
  );
  // A grant in the load_start cycle still needs one DRAIN cycle for its rdata
  always_comb begin
    w_serve = r_state == SERVE;
    w_load = r_state == LOAD;
    w_rd = w_serve && w_any;
    w_wr = w_load && bus.load_valid;
    w_ready = w_rd ? w_gnt : '0;
    w_next = w_serve ? (bus.load_start ? (w_any ? DRAIN : LOAD) : SERVE) :
             (r_state == DRAIN) ? LOAD :
             (bus.load_valid && bus.load_last) ? SERVE : LOAD;
  end
  assign bus.cpu_ready = w_ready;
  assign bus.cpu_data = bus.mem_rdata;
  assign bus.load_ready = w_load;
  assign bus.loading = !w_serve;
  assign bus.mem_en = w_rd || w_wr;
  assign bus.mem_we = w_wr;
  assign bus.mem_addr = w_rd ? bus.cpu_addr[w_idx*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH] :
                        w_wr ? bus.load_addr : '0;
  assign bus.mem_wdata = w_wr ? bus.load_data : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SERVE;
      r_ptr <= PTR_WIDTH'(N_PORTS - 1);
    end else begin
      r_state <= w_next;
      if (w_rd) r_ptr <= w_idx;
    end
  end
`ifdef IMEM_ARB_STATS_EN
  logic [STATS_COUNT_WIDTH-1:0] r_cnt [N_PORTS];
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_PORTS; i++)
      r_cnt[i] <= (reset || stats_clear) ? '0 :
                  (w_ready[i] && !(&r_cnt[i])) ? r_cnt[i] + 1'b1 : r_cnt[i];
  end
  for (genvar g = 0; g < N_PORTS; g++) begin : g_cnt
    assign grant_count[g*STATS_COUNT_WIDTH +: STATS_COUNT_WIDTH] = r_cnt[g];
  end
`endif
endmodule

// File: tb/tb_regex_imem_arbiter.sv
// tb_regex_imem_arbiter: randomized and directed checks of arbitration, drain/load sessions and reset
module tb_regex_imem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int m_ptr = 3;
  always #5 clk = ~clk;
  regex_imem_arbiter_if #(.N_PORTS(4), .MEMORY_ADDR_WIDTH(11), .MEMORY_WIDTH(16)) bus ();
`ifdef IMEM_ARB_STATS_EN
  logic stats_clear = 1'b0;
  logic [63:0] grant_count;
`endif
  regex_imem_arbiter dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
`ifdef IMEM_ARB_STATS_EN
    ,
    .stats_clear(stats_clear),
    .grant_count(grant_count)
`endif
  );

  function automatic logic [15:0] init_val(input logic [10:0] a);
    return (a == 11'h005) ? 16'h1234 : (16'(a) * 16'h9e37) ^ 16'h5a5a;
  endfunction

  bit mem_written [2048];
  logic [15:0] mem [2048];
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      mem_written[bus.mem_addr] <= 1'b1;
    end else if (bus.mem_en) begin
      bus.mem_rdata <= mem_written[bus.mem_addr] ? mem[bus.mem_addr] : init_val(bus.mem_addr);
    end
  end

  bit ref_written [2048];
  logic [15:0] ref_mem [2048];
  function automatic logic [15:0] ref_rd(input logic [10:0] a);
    return ref_written[a] ? ref_mem[a] : init_val(a);
  endfunction

  function automatic int pick(input logic [3:0] v, input int ptr);
    for (int k = 1; k <= 4; k++)
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  task automatic idle_inputs;
    bus.cpu_valid = '0;
    bus.cpu_addr = '0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.load_last = 1'b0;
  endtask

  task automatic set_addr(input int p, input logic [10:0] a);
    bus.cpu_addr[p*11 +: 11] = a;
  endtask

  task automatic do_reset;
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 3;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    total++; if (bus.cpu_ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.cpu_ready); end
    total++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem en=%b we=%b exp=0,0", bus.mem_en, bus.mem_we); end
    total++; if (bus.loading !== 1'b0 || bus.load_ready !== 1'b0) begin bad++; $display("FAIL reset_load loading=%b load_ready=%b exp=0,0", bus.loading, bus.load_ready); end
    total++; if (bus.mem_addr !== 11'h0 || bus.mem_wdata !== 16'h0) begin bad++; $display("FAIL reset_bus addr=%h wdata=%h exp=0,0", bus.mem_addr, bus.mem_wdata); end
  endtask

  task automatic test_single;
    @(negedge clk);
    set_addr(2, 11'h005);
    bus.cpu_valid = 4'b0100;
    #1;
    total++; if (bus.cpu_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b exp=0100", bus.cpu_ready); end
    total++; if (bus.mem_addr !== 11'h005 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL single_mem addr=%h en=%b we=%b exp=005,1,0", bus.mem_addr, bus.mem_en, bus.mem_we); end
    m_ptr = 2;
    @(negedge clk);
    bus.cpu_valid = 4'b0000;
    #1;
    total++; if (bus.cpu_data !== 16'h1234) begin bad++; $display("FAIL single_data got=%h exp=1234", bus.cpu_data); end
    @(negedge clk);
    bus.cpu_valid = 4'b1111;
    #1;
    total++; if (bus.cpu_ready !== 4'b1000) begin bad++; $display("FAIL single_ptr got=%b exp=1000", bus.cpu_ready); end
    m_ptr = 3;
  endtask

  task automatic test_all_requesting;
    logic [10:0] prev_a;
    do_reset();
    for (int p = 0; p < 4; p++) set_addr(p, 11'(16 * p + 3));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.cpu_valid = 4'b1111;
      #1;
      total++; if (bus.cpu_ready !== 4'(1 << (i % 4))) begin bad++; $display("FAIL all_ready cyc=%0d got=%b exp=%b", i, bus.cpu_ready, 4'(1 << (i % 4))); end
      if (i > 0) begin
        total++; if (bus.cpu_data !== ref_rd(prev_a)) begin bad++; $display("FAIL all_data cyc=%0d got=%h exp=%h", i, bus.cpu_data, ref_rd(prev_a)); end
      end
      prev_a = 11'(16 * (i % 4) + 3);
    end
    m_ptr = 3;
  endtask

  task automatic test_alternate;
    logic [3:0] exp;
    @(negedge clk);
    bus.cpu_valid = 4'b0010;
    #1;
    total++; if (bus.cpu_ready !== 4'b0010) begin bad++; $display("FAIL alt_setup got=%b exp=0010", bus.cpu_ready); end
    m_ptr = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.cpu_valid = 4'b1010;
      #1;
      exp = (i % 2 == 0) ? 4'b1000 : 4'b0010;
      total++; if (bus.cpu_ready !== exp) begin bad++; $display("FAIL alt_ready cyc=%0d got=%b exp=%b", i, bus.cpu_ready, exp); end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.cpu_valid = 4'b0000;
      #1;
      total++; if (bus.cpu_ready !== 4'b0 || bus.mem_en !== 1'b0) begin bad++; $display("FAIL alt_idle ready=%b en=%b exp=0,0", bus.cpu_ready, bus.mem_en); end
    end
    @(negedge clk);
    bus.cpu_valid = 4'b1111;
    #1;
    total++; if (bus.cpu_ready !== 4'b0100) begin bad++; $display("FAIL alt_hold got=%b exp=0100", bus.cpu_ready); end
    m_ptr = 2;
  endtask

  task automatic test_random;
    logic [3:0] v;
    logic [10:0] a [4];
    logic [10:0] pa;
    int g, pg;
    pg = -1;
    pa = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      v = 4'($urandom);
      for (int p = 0; p < 4; p++) begin a[p] = 11'($urandom); set_addr(p, a[p]); end
      bus.cpu_valid = v;
      #1;
      g = pick(v, m_ptr);
      total++; if (bus.cpu_ready !== (g < 0 ? 4'b0 : 4'(1 << g))) begin bad++; $display("FAIL rand_ready cyc=%0d req=%b got=%b exp_port=%0d", i, v, bus.cpu_ready, g); end
      if (g >= 0) begin
        total++; if (bus.mem_addr !== a[g] || bus.mem_en !== 1'b1) begin bad++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", i, bus.mem_addr, a[g]); end
        m_ptr = g;
      end
      if (pg >= 0) begin
        total++; if (bus.cpu_data !== ref_rd(pa)) begin bad++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, bus.cpu_data, ref_rd(pa)); end
      end
      pg = g;
      if (g >= 0) pa = a[g];
    end
    @(negedge clk);
    bus.cpu_valid = 4'b0;
  endtask

  task automatic test_load_drain;
    @(negedge clk);
    idle_inputs();
    set_addr(0, 11'h020);
    bus.cpu_valid = 4'b0001;
    bus.load_start = 1'b1;
    #1;
    total++; if (bus.cpu_ready !== 4'b0001) begin bad++; $display("FAIL drain_grant got=%b exp=0001", bus.cpu_ready); end
    m_ptr = 0;
    @(negedge clk);
    bus.load_start = 1'b0;
    bus.cpu_valid = 4'b1111;
    #1;
    total++; if (bus.loading !== 1'b1 || bus.load_ready !== 1'b0) begin bad++; $display("FAIL drain_state loading=%b load_ready=%b exp=1,0", bus.loading, bus.load_ready); end
    total++; if (bus.cpu_ready !== 4'b0 || bus.mem_en !== 1'b0) begin bad++; $display("FAIL drain_nogrant ready=%b en=%b exp=0,0", bus.cpu_ready, bus.mem_en); end
    total++; if (bus.cpu_data !== ref_rd(11'h020)) begin bad++; $display("FAIL drain_data got=%h exp=%h", bus.cpu_data, ref_rd(11'h020)); end
    @(negedge clk);
    #1;
    total++; if (bus.load_ready !== 1'b1 || bus.cpu_ready !== 4'b0) begin bad++; $display("FAIL load_enter load_ready=%b ready=%b exp=1,0", bus.load_ready, bus.cpu_ready); end
    @(negedge clk);
    bus.load_valid = 1'b1;
    bus.load_addr = 11'h010;
    bus.load_data = 16'h00A5;
    bus.load_last = 1'b1;
    #1;
    total++; if (bus.mem_we !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_addr !== 11'h010 || bus.mem_wdata !== 16'h00A5) begin bad++; $display("FAIL load_write we=%b en=%b addr=%h data=%h exp=1,1,010,00a5", bus.mem_we, bus.mem_en, bus.mem_addr, bus.mem_wdata); end
    ref_mem[11'h010] = 16'h00A5;
    ref_written[11'h010] = 1'b1;
    @(negedge clk);
    idle_inputs();
    set_addr(1, 11'h010);
    bus.cpu_valid = 4'b0010;
    #1;
    total++; if (bus.loading !== 1'b0 || bus.cpu_ready !== 4'b0010) begin bad++; $display("FAIL load_exit loading=%b ready=%b exp=0,0010", bus.loading, bus.cpu_ready); end
    m_ptr = 1;
    @(negedge clk);
    bus.cpu_valid = 4'b0;
    #1;
    total++; if (bus.cpu_data !== 16'h00A5) begin bad++; $display("FAIL load_readback got=%h exp=00a5", bus.cpu_data); end
  endtask

  task automatic test_load_stall;
    logic [10:0] wa [2];
    logic [15:0] wd [2];
    @(negedge clk);
    bus.load_start = 1'b1;
    #1;
    total++; if (bus.cpu_ready !== 4'b0) begin bad++; $display("FAIL direct_nogrant got=%b exp=0", bus.cpu_ready); end
    @(negedge clk);
    bus.load_start = 1'b0;
    #1;
    total++; if (bus.load_ready !== 1'b1) begin bad++; $display("FAIL direct_load got=%b exp=1", bus.load_ready); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.cpu_valid = 4'b1111;
      bus.load_start = 1'($urandom);
      #1;
      total++; if (bus.cpu_ready !== 4'b0 || bus.mem_we !== 1'b0 || bus.loading !== 1'b1) begin bad++; $display("FAIL stall cyc=%0d ready=%b we=%b loading=%b exp=0,0,1", i, bus.cpu_ready, bus.mem_we, bus.loading); end
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      wa[j] = 11'(12'h100 + j * 7);
      wd[j] = 16'($urandom);
      bus.load_start = 1'b0;
      bus.load_valid = 1'b1;
      bus.load_addr = wa[j];
      bus.load_data = wd[j];
      bus.load_last = (j == 1);
      #1;
      total++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== wa[j] || bus.cpu_ready !== 4'b0) begin bad++; $display("FAIL stall_write w=%0d we=%b addr=%h ready=%b exp=1,%h,0", j, bus.mem_we, bus.mem_addr, bus.cpu_ready, wa[j]); end
      ref_mem[wa[j]] = wd[j];
      ref_written[wa[j]] = 1'b1;
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      idle_inputs();
      set_addr(3, wa[j]);
      bus.cpu_valid = 4'b1000;
      #1;
      total++; if (bus.cpu_ready !== 4'b1000) begin bad++; $display("FAIL stall_exit w=%0d got=%b exp=1000", j, bus.cpu_ready); end
      m_ptr = 3;
      @(negedge clk);
      bus.cpu_valid = 4'b0;
      #1;
      total++; if (bus.cpu_data !== ref_rd(wa[j])) begin bad++; $display("FAIL stall_readback w=%0d got=%h exp=%h", j, bus.cpu_data, ref_rd(wa[j])); end
    end
  endtask

  task automatic test_reset_mid_load;
    logic [15:0] d;
    d = 16'($urandom);
    @(negedge clk);
    idle_inputs();
    m_ptr = 0;
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_addr = 11'h030;
    bus.load_data = d;
    ref_mem[11'h030] = d;
    ref_written[11'h030] = 1'b1;
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 3;
    #1;
    total++; if (bus.loading !== 1'b0 || bus.load_ready !== 1'b0) begin bad++; $display("FAIL rst_load loading=%b load_ready=%b exp=0,0", bus.loading, bus.load_ready); end
    @(negedge clk);
    bus.cpu_valid = 4'b1111;
    #1;
    total++; if (bus.cpu_ready !== 4'b0001) begin bad++; $display("FAIL rst_first got=%b exp=0001", bus.cpu_ready); end
    m_ptr = 0;
    @(negedge clk);
    set_addr(2, 11'h030);
    bus.cpu_valid = 4'b0100;
    #1;
    total++; if (bus.cpu_ready !== 4'b0100) begin bad++; $display("FAIL rst_partial_grant got=%b exp=0100", bus.cpu_ready); end
    m_ptr = 2;
    @(negedge clk);
    bus.cpu_valid = 4'b0;
    #1;
    total++; if (bus.cpu_data !== d) begin bad++; $display("FAIL rst_partial_data got=%h exp=%h", bus.cpu_data, d); end
  endtask

`ifdef IMEM_ARB_STATS_EN
  task automatic test_stats;
    do_reset();
    #1;
    total++; if (grant_count !== 64'h0) begin bad++; $display("FAIL stats_reset got=%h exp=0", grant_count); end
    @(negedge clk);
    bus.cpu_valid = 4'b0001;
    repeat (100) @(negedge clk);
    bus.cpu_valid = 4'b0;
    #1;
    total++; if (grant_count[15:0] !== 16'd100) begin bad++; $display("FAIL stats_100 got=%0d exp=100", grant_count[15:0]); end
    @(negedge clk);
    bus.cpu_valid = 4'b0001;
    repeat (69900) @(negedge clk);
    bus.cpu_valid = 4'b0;
    #1;
    total++; if (grant_count !== 64'h0000_0000_0000_FFFF) begin bad++; $display("FAIL stats_sat got=%h exp=000000000000ffff", grant_count); end
    @(negedge clk);
    bus.cpu_valid = 4'b0001;
    stats_clear = 1'b1;
    @(negedge clk);
    bus.cpu_valid = 4'b0;
    stats_clear = 1'b0;
    #1;
    total++; if (grant_count !== 64'h0) begin bad++; $display("FAIL stats_clear got=%h exp=0", grant_count); end
  endtask
`endif

  initial begin
    #900000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_all_requesting();
    test_alternate();
    test_random();
    test_load_drain();
    test_load_stall();
    test_reset_mid_load();
    test_random();
`ifdef IMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regex_imem_arbiter.md
Name: regex_imem_arbiter

Overview:
- Shares one synchronous-read instruction memory among N_PORTS pipelined regex CPUs, using round-robin arbitration on each CPU's memory_valid/memory_ready fetch port.
- Also owns the single program-load write path: a load session stalls all CPU fetches, drains any outstanding read, then streams instruction words into memory.
- Sits between the CPU array and the instruction BRAM, below the top-level regex coprocessor controller.

Parameters:
N_PORTS, 4, number of CPU fetch ports (>=2)
MEMORY_ADDR_WIDTH, 11, memory address width
MEMORY_WIDTH, 16, memory word width
PTR_WIDTH, $clog2(N_PORTS), round-robin pointer width (derived, not overridden)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
cpu_valid  in  N_PORTS  per-CPU fetch request (memory_valid)
cpu_addr  in  N_PORTS*MEMORY_ADDR_WIDTH  packed fetch addresses; port i at [i*MEMORY_ADDR_WIDTH+:MEMORY_ADDR_WIDTH]
cpu_ready  out  N_PORTS  per-CPU grant (memory_ready); at most one bit high
cpu_data  out  MEMORY_WIDTH  read data broadcast to all CPUs; valid the cycle after that CPU's grant
load_start  in  1  pulse; requests a program-load session
load_valid  in  1  load word valid
load_addr  in  MEMORY_ADDR_WIDTH  load write address
load_data  in  MEMORY_WIDTH  load write data
load_last  in  1  marks the final load word, qualified by load_valid
load_ready  out  1  load word accepted
loading  out  1  high while the load session is active (DRAIN or LOAD)
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  MEMORY_ADDR_WIDTH  memory address
mem_wdata  out  MEMORY_WIDTH  memory write data
mem_rdata  in  MEMORY_WIDTH  memory read data, 1-cycle read latency

Behaviour:
- Reset values:
  - state = SERVE, rr_ptr = N_PORTS-1, rd_pending = 0.
  - All outputs 0 except cpu_data, which tracks mem_rdata.
- Read path:
  - cpu_data = mem_rdata combinationally.
  - A grant at cycle t yields data at t+1, so a CPU sampling memory_data the cycle after its handshake gets its word.
- FSM states:
  - SERVE: arbitrate reads.
    - If load_start is seen, move to DRAIN if a read was granted this cycle, else directly to LOAD.
    - The granting decision in the cycle load_start is seen is still made normally.
  - DRAIN: no grants; one cycle so the outstanding rdata reaches its CPU; then go to LOAD.
  - LOAD:
    - load_ready = 1. On load_valid: mem_en = 1, mem_we = 1, mem_addr = load_addr, mem_wdata = load_data.
    - On load_valid && load_last, return to SERVE next cycle.
    - No cpu_ready while in LOAD.
- Arbitration (SERVE only):
  - Search order is rr_ptr+1, rr_ptr+2, … modulo N_PORTS; the first port with cpu_valid high is granted.
  - cpu_ready is combinational from cpu_valid; mem_en = 1, mem_we = 0, mem_addr = granted port's address.
  - rr_ptr is updated to the granted index only on a grant; it holds when idle.
  - Wrap: N_PORTS-1 → 0.
- One grant per cycle; throughput is one fetch per cycle total.
- A CPU whose cpu_valid drops without a grant is not remembered.
- Fairness: any continuously requesting port is granted within N_PORTS cycles in SERVE.
- loading = (state != SERVE).
- load_start while already in DRAIN or LOAD is ignored.
- Data written during LOAD is readable by the first grant after returning to SERVE; no hazard bypass is needed, since the write completes before that read.
- Reset mid-LOAD: return to SERVE; the partial program is left in memory; the controller must restart the load.

Optional Feature:
- Macro IMEM_ARB_STATS_EN.
- With it defined:
  - Adds output grant_count, N_PORTS*16 bits: per-port saturating 16-bit grant counters, stopping at 16'hFFFF.
  - Adds input stats_clear: a pulse that zeroes all counters; clear wins over a same-cycle increment.
  - Counters reset to 0.
- Without it: those ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package gets:
  - arbiter state enum {SERVE, DRAIN, LOAD}
  - STATS_COUNT_WIDTH = 16
- One natural sub-module: rr_priority_picker (combinational one-hot pick from a request vector and a pointer), reusable by other arbiters.
- The FSM, pointer and memory muxing stay in the top module.

Test Plan:
- Single requester: port 2 requests addr 0x005, mem holds 0x1234 there → cpu_ready = 0100 in the same cycle; cpu_data = 0x1234 next cycle; rr_ptr = 2.
- All 4 requesting continuously from reset → grants in order 0,1,2,3,0,1,… one per cycle; no port is granted twice within 4 cycles.
- Ports 1 and 3 requesting, rr_ptr = 1 → port 3 first, then 1, alternating; when idle, rr_ptr holds its value.
- load_start during a grant to port 0:
  - Cycle 0: grant.
  - Cycle 1: DRAIN, cpu_data valid for port 0, cpu_ready = 0.
  - Cycle 2: LOAD.
  - Write 0x00A5 at 0x010 with load_last, then return to SERVE.
  - A fetch of 0x010 returns 0x00A5.
- load_valid held low in LOAD for 10 cycles with CPUs requesting → no cpu_ready, no mem_we, loading = 1 throughout.
- Reset asserted mid-LOAD, then deasserted → loading = 0, SERVE, rr_ptr = 3; the first request from port 0 is granted.
- IMEM_ARB_STATS_EN: 70000 grants to port 0 → its counter reads 0xFFFF; stats_clear together with a grant → 0.
